// File: rtl/alu_pkg.sv
// ALU exec unit shared definitions: opcodes, FSM states, legality.
// ALU_EXEC_MUL_EN moves opcode 8 (MUL) into the legal range.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Illegal opcodes span OP_ILL_LO..15.
`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_ILL_LO = OP_MUL + 4'd1;
`else
  localparam logic [3:0] OP_ILL_LO = OP_MUL;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return op < OP_ILL_LO;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for opcodes 0..7 with Z/N/C/V generation.
// SUB is formed as A + ~B + 1 so C means "no borrow".
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        {c, y} = {1'b0, a} + {1'b0, b};
        v = (a[MSB] == b[MSB]) &&
            (y[MSB] != a[MSB]);
      end
      (op == OP_SUB): begin
        {c, y} = {1'b0, a} + {1'b0, ~b}
               + (WIDTH+1)'(1);
        v = (a[MSB] != b[MSB]) &&
            (y[MSB] != a[MSB]);
      end
      (op == OP_AND): y = a & b;
      (op == OP_OR):  y = a | b;
      (op == OP_XOR): y = a ^ b;
      (op == OP_NOT): y = ~a;
      (op == OP_SHL): begin
        y = {a[MSB-1:0], 1'b0};
        c = a[MSB];
      end
      (op == OP_SHR): begin
        y = {1'b0, a[MSB:1]};
        c = a[0];
      end
      default: begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
      end
    endcase
  end

  assign z = (y == '0);
  assign n = y[MSB];

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU with IDLE/EXEC/DONE handshake and registered flags.
// Define ALU_EXEC_MUL_EN to build the shift-add multiplier (opcode 8).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  input  logic             ack,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             err,
  output logic             busy,
  output logic             done
);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             cap, is_mul, finish;

  logic [WIDTH-1:0] y_c;
  logic             z_c, n_c, c_c, v_c;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (y_c),
    .z  (z_c),
    .n  (n_c),
    .c  (c_c),
    .v  (v_c)
  );

  assign cap = start && ((state == S_IDLE) ||
               ((state == S_DONE) && ack));

`ifdef ALU_EXEC_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_nx;

  assign is_mul = (op_q == OP_MUL);
  assign finish = !is_mul || (cnt == CW'(WIDTH-1));
  assign acc_nx = acc + (b_q[0] ? mcand : '0);

  // One partial product per cycle; b_q is consumed LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
    end else if (cap) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, A};
    end else if (state == S_EXEC && is_mul) begin
      cnt   <= cnt + CW'(1);
      acc   <= acc_nx;
      mcand <= mcand << 1;
    end
  end
`else
  assign is_mul = 1'b0;
  assign finish = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_EXEC;
      S_EXEC: if (finish) state_nx = S_DONE;
      S_DONE: begin
        if (ack) state_nx = start ? S_EXEC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_EXEC);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      {Z, N, C, V, err} <= '0;
    end else if (cap) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= opcode;
    end else if (state == S_EXEC) begin
`ifdef ALU_EXEC_MUL_EN
      if (is_mul) b_q <= b_q >> 1;
`endif
      if (finish) begin
        if (!op_legal(op_q)) begin
          result <= '0;
          {Z, N, C, V, err} <= 5'b10001;
`ifdef ALU_EXEC_MUL_EN
        end else if (is_mul) begin
          result <= acc_nx[WIDTH-1:0];
          Z      <= (acc_nx[WIDTH-1:0] == '0);
          N      <= acc_nx[WIDTH-1];
          C      <= |acc_nx[2*WIDTH-1:WIDTH];
          V      <= |acc_nx[2*WIDTH-1:WIDTH];
          err    <= 1'b0;
`endif
        end else begin
          result <= y_c;
          {Z, N, C, V, err} <=
            {z_c, n_c, c_c, v_c, 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=8) with a behavioural model.
// Works with ALU_EXEC_MUL_EN defined or undefined.
module tb_alu_exec_unit;

  localparam int W = 8;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] res;
    logic z, n, c, v, err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   opcode = '0;
  logic         ack = 1'b0;
  logic [W-1:0] result;
  logic         Z, N, C, V, err, busy, done;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;
  bit   in_done = 1'b0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B), .opcode(opcode), .ack(ack),
    .result(result), .Z(Z), .N(N), .C(C),
    .V(V), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference model built from the arithmetic definition of each op.
  function automatic exp_t model(input logic [3:0] op,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t m;
    int unsigned ua, ub, r;
    int sa, sb, s;
    bit c, v, e;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; c = 0; v = 0; e = 0;
    case (op)
      4'd0: begin
        r = ua + ub; c = r > 255;
        s = sa + sb; v = (s > 127) || (s < -128);
      end
      4'd1: begin
        r = ua + (255 - ub) + 1; c = r > 255;
        s = sa - sb; v = (s > 127) || (s < -128);
      end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = 255 - ua;
      4'd6: begin r = ua * 2; c = ua >= 128; end
      4'd7: begin r = ua / 2; c = (ua % 2) == 1; end
      4'd8: begin
        if (MUL_ON) begin
          r = ua * ub; c = (r / 256) != 0; v = c;
        end else e = 1;
      end
      default: e = 1;
    endcase
    r = r % 256;
    if (e) begin r = 0; c = 0; v = 0; end
    m.res = r[7:0];
    m.z = (r == 0);
    m.n = (r >= 128);
    m.c = c;
    m.v = v;
    m.err = e;
    return m;
  endfunction

  // Monitor: pop on done rising, then hold-check every DONE cycle.
  always @(negedge clk) begin
    if (done) begin
      if (!in_done) begin
        if (q.size() == 0) begin
          check("sb_unexpected_done", 1, 0);
          cur = '0;
        end else begin
          cur = q.pop_front();
        end
        in_done = 1'b1;
      end
      check("result_flags",
            {19'd0, result, Z, N, C, V, err},
            {19'd0, cur});
    end else begin
      in_done = 1'b0;
    end
  end

  task automatic scramble();
    A = W'($urandom);
    B = W'($urandom);
    opcode = 4'($urandom);
  endtask

  task automatic send(input logic [3:0] op,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input bit with_ack);
    int n, lat;
    lat = (op == 4'd8 && MUL_ON) ? W + 1 : 2;
    start = 1'b1; ack = with_ack;
    A = a; B = b; opcode = op;
    q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    scramble();
    check("busy_after_start", {31'd0, busy}, 1);
    n = 1;
    while (!done && n < 200) begin
      start = 1'($urandom_range(0, 1));
      scramble();
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
    else check("latency", n, lat);
    repeat ($urandom_range(0, 3)) begin
      start = 1'($urandom_range(0, 1));
      scramble();
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic release_done();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("idle_after_ack", {30'd0, busy, done}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out",
          {18'd0, result, Z, N, C, V, err, busy, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(4'h0, 8'hFF, 8'h01, 0);
    release_done();
    send(4'h1, 8'h80, 8'h01, 0);
    send(4'h1, 8'h00, 8'h01, 1);
    send(4'h8, 8'h10, 8'h10, 1);
    send(4'h8, 8'h0F, 8'h03, 1);
    send(4'hF, 8'h12, 8'h34, 1);
    send(4'h0, 8'h01, 8'h01, 1);
    release_done();

    // Abort an in-flight op with an asynchronous reset.
    start = 1'b1; A = 8'h10; B = 8'h10;
    opcode = MUL_ON ? 4'h8 : 4'h0;
    @(negedge clk);
    start = 1'b0;
    if (MUL_ON) repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_reset",
             {22'd0, result, err, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'h0, 8'h02, 8'h03, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'h8
           : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        send(op, 8'($urandom), 8'($urandom), 1);
      end else begin
        release_done();
        send(op, 8'($urandom), 8'($urandom), 0);
      end
    end
    release_done();
    repeat (2) @(negedge clk);
    check("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
